// File: rtl/tl45_regread_if.sv
// Decode-to-ALU bundle for the TL45 register-read stage: instruction fields,
// forwarding/writeback ports, stall/flush handshake and the registered operand buffer.
interface tl45_regread_if;
  logic        i_pipe_stall;
  logic        o_pipe_stall;
  logic        i_pipe_flush;
  logic        o_pipe_flush;
  logic [4:0]  i_opcode;
  logic [3:0]  i_dr;
  logic [3:0]  i_sr1;
  logic [3:0]  i_sr2;
  logic        i_use_imm;
  logic [31:0] i_imm;
  logic [3:0]  i_jmp_cond;
  logic [31:0] i_pc;
  logic [3:0]  i_of1_reg;
  logic [31:0] i_of1_val;
  logic [3:0]  i_of2_reg;
  logic [31:0] i_of2_val;
  logic [3:0]  i_ld_pend_reg;
  logic [3:0]  i_wb_reg;
  logic [31:0] i_wb_val;
  logic [4:0]  o_opcode;
  logic [3:0]  o_dr;
  logic [3:0]  o_jmp_cond;
  logic [31:0] o_sr1_val;
  logic [31:0] o_sr2_val;
  logic [31:0] o_target_offset;
  logic [31:0] o_pc;

  modport master (
    output i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1, i_sr2, i_use_imm,
           i_imm, i_jmp_cond, i_pc, i_of1_reg, i_of1_val, i_of2_reg, i_of2_val,
           i_ld_pend_reg, i_wb_reg, i_wb_val,
    input  o_pipe_stall, o_pipe_flush, o_opcode, o_dr, o_jmp_cond, o_sr1_val,
           o_sr2_val, o_target_offset, o_pc
  );

  modport slave (
    input  i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1, i_sr2, i_use_imm,
           i_imm, i_jmp_cond, i_pc, i_of1_reg, i_of1_val, i_of2_reg, i_of2_val,
           i_ld_pend_reg, i_wb_reg, i_wb_val,
    output o_pipe_stall, o_pipe_flush, o_opcode, o_dr, o_jmp_cond, o_sr1_val,
           o_sr2_val, o_target_offset, o_pc
  );
endinterface

// File: rtl/tl45_regread.sv
// TL45 register-read stage: register file, operand forwarding, load-use bubble
// insertion and the registered operand buffer feeding the ALU.
module tl45_regread (
  input logic           i_clk,
  input logic           i_reset_n,
  tl45_regread_if.slave bus
);

  typedef struct packed {
    logic [4:0]  opcode;
    logic [3:0]  dr;
    logic [3:0]  jmp_cond;
    logic [31:0] sr1_val;
    logic [31:0] sr2_val;
    logic [31:0] target_offset;
    logic [31:0] pc;
  } buf_t;

  logic [31:0] r_regs [16];
  buf_t        r_buf;
  buf_t        w_next;
  logic [31:0] w_sr1_val;
  logic [31:0] w_sr2_val;
  logic        w_hazard;

  // Youngest producer wins: ALU, then memory, then the same-cycle writeback.
  function automatic logic [31:0] f_resolve(
    input logic [3:0]  idx,
    input logic [31:0] rf_val,
    input logic [3:0]  of1_reg,
    input logic [31:0] of1_val,
    input logic [3:0]  of2_reg,
    input logic [31:0] of2_val,
    input logic [3:0]  wb_reg,
    input logic [31:0] wb_val
  );
    logic [31:0] v;
    if (idx == 4'd0) begin
      v = 32'd0;
    end else if (idx == of1_reg) begin
      v = of1_val;
    end else if (idx == of2_reg) begin
      v = of2_val;
    end else if (idx == wb_reg) begin
      v = wb_val;
    end else begin
      v = rf_val;
    end
    return v;
  endfunction

  // Register file; entry 0 is never written so it stays at its reset value of 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (bus.i_wb_reg != 4'd0) begin
      r_regs[bus.i_wb_reg] <= bus.i_wb_val;
    end
  end

  // Operand resolution and load-use hazard detection.
  always_comb begin
    w_sr1_val = f_resolve(bus.i_sr1, r_regs[bus.i_sr1], bus.i_of1_reg, bus.i_of1_val,
                          bus.i_of2_reg, bus.i_of2_val, bus.i_wb_reg, bus.i_wb_val);
    w_sr2_val = 32'd0;
    w_hazard  = 1'b0;
    if (bus.i_use_imm) begin
      w_sr2_val = bus.i_imm;
    end else begin
      w_sr2_val = f_resolve(bus.i_sr2, r_regs[bus.i_sr2], bus.i_of1_reg, bus.i_of1_val,
                            bus.i_of2_reg, bus.i_of2_val, bus.i_wb_reg, bus.i_wb_val);
    end
    if (bus.i_ld_pend_reg == 4'd0) begin
      w_hazard = 1'b0;
    end else if (bus.i_ld_pend_reg == bus.i_sr1) begin
      w_hazard = 1'b1;
    end else if (!bus.i_use_imm && (bus.i_ld_pend_reg == bus.i_sr2)) begin
      w_hazard = 1'b1;
    end else begin
      w_hazard = 1'b0;
    end
    w_next.opcode        = bus.i_opcode;
    w_next.dr            = bus.i_dr;
    w_next.jmp_cond      = bus.i_jmp_cond;
    w_next.sr1_val       = w_sr1_val;
    w_next.sr2_val       = w_sr2_val;
    w_next.target_offset = bus.i_imm;
    w_next.pc            = bus.i_pc;
  end

  // Operand buffer: flush clears, stall holds, a hazard loads an all-zero NOP.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf <= '0;
    end else if (bus.i_pipe_flush) begin
      r_buf <= '0;
    end else if (!bus.i_pipe_stall) begin
      if (w_hazard) begin
        r_buf <= '0;
      end else begin
        r_buf <= w_next;
      end
    end
  end

  assign bus.o_pipe_stall    = bus.i_pipe_stall | (w_hazard & ~bus.i_pipe_flush);
  assign bus.o_pipe_flush    = bus.i_pipe_flush;
  assign bus.o_opcode        = r_buf.opcode;
  assign bus.o_dr            = r_buf.dr;
  assign bus.o_jmp_cond      = r_buf.jmp_cond;
  assign bus.o_sr1_val       = r_buf.sr1_val;
  assign bus.o_sr2_val       = r_buf.sr2_val;
  assign bus.o_target_offset = r_buf.target_offset;
  assign bus.o_pc            = r_buf.pc;

endmodule

// File: tb/tb_tl45_regread.sv
// Scoreboard bench for tl45_regread: directed scenarios plus randomized traffic,
// expected responses queued from a behavioural model and checked by separate monitors.
module tb_tl45_regread;

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  dr;
    logic [3:0]  jc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] off;
    logic [31:0] pc;
  } buf_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] m_rf [16];
  buf_t        m_buf;
  buf_t        exp_buf_q [$];
  logic [1:0]  exp_ctrl_q [$];

  tl45_regread_if bus();

  tl45_regread dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // An operand is the most recent value any later stage holds for that register.
  function automatic logic [31:0] m_operand(input logic [3:0] idx);
    if (idx == 4'd0)          return 32'd0;
    if (idx == bus.i_of1_reg) return bus.i_of1_val;
    if (idx == bus.i_of2_reg) return bus.i_of2_val;
    if (idx == bus.i_wb_reg)  return bus.i_wb_val;
    return m_rf[idx];
  endfunction

  task automatic idle();
    bus.i_pipe_stall  = 1'b0;  bus.i_pipe_flush = 1'b0;
    bus.i_opcode      = 5'd0;  bus.i_dr         = 4'd0;
    bus.i_sr1         = 4'd0;  bus.i_sr2        = 4'd0;
    bus.i_use_imm     = 1'b0;  bus.i_imm        = 32'd0;
    bus.i_jmp_cond    = 4'd0;  bus.i_pc         = 32'd0;
    bus.i_of1_reg     = 4'd0;  bus.i_of1_val    = 32'd0;
    bus.i_of2_reg     = 4'd0;  bus.i_of2_val    = 32'd0;
    bus.i_ld_pend_reg = 4'd0;  bus.i_wb_reg     = 4'd0;
    bus.i_wb_val      = 32'd0;
  endtask

  // Queue the expected response for the current inputs, then let one edge pass.
  task automatic cycle();
    logic haz;
    buf_t nxt;
    @(negedge clk);
    haz = (bus.i_ld_pend_reg != 4'd0) &&
          ((bus.i_ld_pend_reg == bus.i_sr1) ||
           (!bus.i_use_imm && (bus.i_ld_pend_reg == bus.i_sr2)));
    exp_ctrl_q.push_back({bus.i_pipe_stall | (haz & ~bus.i_pipe_flush), bus.i_pipe_flush});
    nxt.op  = bus.i_opcode;
    nxt.dr  = bus.i_dr;
    nxt.jc  = bus.i_jmp_cond;
    nxt.s1  = m_operand(bus.i_sr1);
    nxt.s2  = bus.i_use_imm ? bus.i_imm : m_operand(bus.i_sr2);
    nxt.off = bus.i_imm;
    nxt.pc  = bus.i_pc;
    if (bus.i_pipe_flush)      m_buf = '0;
    else if (bus.i_pipe_stall) m_buf = m_buf;
    else if (haz)              m_buf = '0;
    else                       m_buf = nxt;
    exp_buf_q.push_back(m_buf);
    @(posedge clk);
    if (bus.i_wb_reg != 4'd0) m_rf[bus.i_wb_reg] = bus.i_wb_val;
    #1;
  endtask

  // Buffer monitor: compares the registered outputs just after every edge.
  initial begin
    buf_t e;
    buf_t g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_buf_q.size() != 0) begin
        e = exp_buf_q.pop_front();
        g = {bus.o_opcode, bus.o_dr, bus.o_jmp_cond, bus.o_sr1_val, bus.o_sr2_val,
             bus.o_target_offset, bus.o_pc};
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL sb_buf: got %h expected %h", g, e);
        end
      end
    end
  end

  // Control monitor: compares the combinational stall/flush outputs mid-cycle.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_ctrl_q.size() != 0) begin
        e = exp_ctrl_q.pop_front();
        n_checks++;
        if ({bus.o_pipe_stall, bus.o_pipe_flush} !== e) begin
          n_fail++;
          $display("FAIL sb_ctrl: got %b expected %b", {bus.o_pipe_stall, bus.o_pipe_flush}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_all_zero(input string name);
    check({name, "_op"},  {27'd0, bus.o_opcode}, 32'd0);
    check({name, "_dr"},  {24'd0, bus.o_dr, bus.o_jmp_cond}, 32'd0);
    check({name, "_s1"},  bus.o_sr1_val, 32'd0);
    check({name, "_s2"},  bus.o_sr2_val, 32'd0);
    check({name, "_off"}, bus.o_target_offset, 32'd0);
    check({name, "_pc"},  bus.o_pc, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    m_buf = '0;
    idle();
    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback r3, then ADD r1,r3,r0.
    bus.i_wb_reg = 4'd3; bus.i_wb_val = 32'h0000_1234;
    cycle();
    idle();
    bus.i_opcode = 5'd1; bus.i_dr = 4'd1; bus.i_sr1 = 4'd3; bus.i_sr2 = 4'd0;
    cycle();
    check("add_s1", bus.o_sr1_val, 32'h0000_1234);
    check("add_s2", bus.o_sr2_val, 32'd0);
    check("add_dr", {28'd0, bus.o_dr}, 32'd1);

    // Forwarding priority on r2.
    idle();
    bus.i_wb_reg = 4'd2; bus.i_wb_val = 32'd5;
    cycle();
    idle();
    bus.i_opcode = 5'd1; bus.i_dr = 4'd7; bus.i_sr1 = 4'd2;
    bus.i_of1_reg = 4'd2; bus.i_of1_val = 32'd9;
    bus.i_of2_reg = 4'd2; bus.i_of2_val = 32'd7;
    cycle();
    check("fwd_of1", bus.o_sr1_val, 32'd9);
    bus.i_of1_reg = 4'd0;
    cycle();
    check("fwd_of2", bus.o_sr1_val, 32'd7);
    bus.i_of2_reg = 4'd0;
    cycle();
    check("fwd_rf", bus.o_sr1_val, 32'd5);

    // Load-use hazard: SUB r5,r4,r6 behind a load to r4.
    idle();
    bus.i_opcode = 5'd2; bus.i_dr = 4'd5; bus.i_sr1 = 4'd4; bus.i_sr2 = 4'd6;
    bus.i_ld_pend_reg = 4'd4;
    #1;
    check("haz_stall", {31'd0, bus.o_pipe_stall}, 32'd1);
    cycle();
    check_all_zero("haz_bubble");
    bus.i_ld_pend_reg = 4'd0; bus.i_of2_reg = 4'd4; bus.i_of2_val = 32'h0000_00AA;
    cycle();
    check("haz_issue_s1", bus.o_sr1_val, 32'h0000_00AA);
    check("haz_issue_op", {27'd0, bus.o_opcode}, 32'd2);

    // Immediate operand masks the sr2 hazard.
    idle();
    bus.i_opcode = 5'd3; bus.i_dr = 4'd6; bus.i_sr1 = 4'd1; bus.i_sr2 = 4'd4;
    bus.i_use_imm = 1'b1; bus.i_imm = 32'hFFFF_FFFC; bus.i_ld_pend_reg = 4'd4;
    #1;
    check("imm_no_stall", {31'd0, bus.o_pipe_stall}, 32'd0);
    cycle();
    check("imm_s2", bus.o_sr2_val, 32'hFFFF_FFFC);

    // Stall for three cycles with changing inputs, then flush during the stall.
    for (int k = 0; k < 3; k++) begin
      bus.i_pipe_stall = 1'b1;
      bus.i_opcode = 5'(k + 8); bus.i_imm = $urandom; bus.i_pc = $urandom;
      bus.i_sr1 = 4'(k + 1); bus.i_ld_pend_reg = 4'(k + 1);
      #1;
      check("stall_req", {31'd0, bus.o_pipe_stall}, 32'd1);
      cycle();
      check("stall_hold_op", {27'd0, bus.o_opcode}, 32'd3);
      check("stall_hold_s2", bus.o_sr2_val, 32'hFFFF_FFFC);
    end
    bus.i_pipe_flush = 1'b1;
    cycle();
    check_all_zero("flush");

    // Branch in the buffer, then asynchronous reset between edges.
    idle();
    bus.i_opcode = 5'h0C; bus.i_jmp_cond = 4'd5; bus.i_imm = 32'h0000_0040;
    bus.i_pc = 32'h0000_1000; bus.i_wb_reg = 4'd3; bus.i_wb_val = 32'h0000_0077;
    cycle();
    check("branch_op", {27'd0, bus.o_opcode}, 32'h0000_000C);
    bus.i_pipe_stall = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    m_buf = '0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    bus.i_opcode = 5'd1; bus.i_dr = 4'd2; bus.i_sr1 = 4'd3; bus.i_sr2 = 4'd3;
    cycle();
    check("rst_r3", bus.o_sr1_val, 32'd0);

    // Randomized traffic with a narrow register range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      bus.i_pipe_stall  = ($urandom_range(0, 4) == 0);
      bus.i_pipe_flush  = ($urandom_range(0, 9) == 0);
      bus.i_opcode      = 5'($urandom);
      bus.i_dr          = 4'($urandom);
      bus.i_sr1         = 4'($urandom_range(0, 7));
      bus.i_sr2         = 4'($urandom_range(0, 7));
      bus.i_use_imm     = ($urandom_range(0, 2) == 0);
      bus.i_imm         = $urandom;
      bus.i_jmp_cond    = 4'($urandom);
      bus.i_pc          = $urandom;
      bus.i_of1_reg     = 4'($urandom_range(0, 7));
      bus.i_of1_val     = $urandom;
      bus.i_of2_reg     = 4'($urandom_range(0, 7));
      bus.i_of2_val     = $urandom;
      bus.i_ld_pend_reg = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      bus.i_wb_reg      = 4'($urandom_range(0, 7));
      bus.i_wb_val      = $urandom;
      cycle();
    end

    idle();
    cycle();
    @(negedge clk);
    #3;
    check("sb_buf_drain", exp_buf_q.size(), 32'd0);
    check("sb_ctrl_drain", exp_ctrl_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl45_regread.md
# tl45_regread

Register-read stage of the TL45 pipeline, directly upstream of the ALU stage. It takes a decoded instruction, reads both source operands from the 15-entry general register file (r0 is hardwired to zero), and resolves forwarding from the ALU, memory and writeback stages. It detects load-use hazards and inserts bubbles for them, then presents a registered operand buffer to the ALU. It also owns the register file write port driven by writeback.

## Interface
Parameters:
- none.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset_n`  in  1  reset; asynchronous, active-low.
- `i_pipe_stall`  in  1  downstream stall request.
- `o_pipe_stall`  out  1  stall request to decode.
- `i_pipe_flush`  in  1  flush request from downstream.
- `o_pipe_flush`  out  1  flush forwarded to decode.
- `i_opcode`  in  5  decoded opcode.
- `i_dr`  in  4  destination register.
- `i_sr1`  in  4  source 1 register.
- `i_sr2`  in  4  source 2 register.
- `i_use_imm`  in  1  1: the sr2 operand is `i_imm`.
- `i_imm`  in  32  sign-extended immediate; also used as the branch offset.
- `i_jmp_cond`  in  4  branch condition code.
- `i_pc`  in  32  instruction PC.
- `i_of1_reg`  in  4  ALU forward register.
- `i_of1_val`  in  32  ALU forward value.
- `i_of2_reg`  in  4  memory-stage forward register.
- `i_of2_val`  in  32  memory-stage forward value.
- `i_ld_pend_reg`  in  4  destination of a load in flight in the ALU stage; 0 means none.
- `i_wb_reg`  in  4  writeback register; 0 means no write.
- `i_wb_val`  in  32  writeback value.
- `o_opcode`  out  5  buffered opcode.
- `o_dr`  out  4  buffered destination register.
- `o_jmp_cond`  out  4  buffered condition code.
- `o_sr1_val`  out  32  buffered operand 1.
- `o_sr2_val`  out  32  buffered operand 2.
- `o_target_offset`  out  32  buffered immediate.
- `o_pc`  out  32  buffered PC.

## Operation
- Register file:
  - Holds r1..r15, 32 bits each.
  - Writes `i_wb_val` to `i_wb_reg` on a clock edge when `i_wb_reg != 0`. The write happens regardless of stall or flush.
  - Reads of r0 return 0.
- Operand resolution, per source, in priority order:
  1. If the source index is 0, the value is 0.
  2. If it matches `i_of1_reg`, use `i_of1_val`.
  3. If it matches `i_of2_reg`, use `i_of2_val`.
  4. If it matches `i_wb_reg`, use `i_wb_val` (same-cycle write bypass).
  5. Otherwise use the register file content.
- Operand 2 selection: when `i_use_imm=1`, operand 2 is `i_imm` and `i_sr2` is ignored, including for the hazard check.
- Load-use hazard (`hazard`):
  - Asserted when `i_ld_pend_reg != 0` and it equals `i_sr1`.
  - Also asserted when it equals `i_sr2` and `i_use_imm=0`.
- Buffer update priority on each edge:
  1. Flush (`i_pipe_flush`): all outputs are cleared to 0.
  2. Stall (`i_pipe_stall`): the buffer holds its value.
  3. Hazard: a bubble is loaded (all outputs 0).
  4. Otherwise the buffer loads the resolved instruction.
- Control outputs:
  - `o_pipe_stall = i_pipe_stall | (hazard & !i_pipe_flush)`.
  - `o_pipe_flush = i_pipe_flush`. This stage never originates a flush.
- Flush contract: an all-zero buffer (opcode 0) is a NOP to the ALU. Every output is 0 in the cycle after a flush.

## Timing
- Reset: all buffer outputs and all 15 registers become 0 immediately on `i_reset_n=0`. They stay 0 until the first edge with `i_reset_n=1`.
- Latency: one cycle from the `i_*` instruction inputs to the `o_*` buffer.
- Forwarding and hazard logic are combinational on the current inputs. They are sampled at the edge that loads the buffer.
- A hazard holds decode for exactly one cycle per pending load. On the next cycle the load value arrives via `i_of2_*` and `i_ld_pend_reg` is 0.
- Simultaneous events:
  - Flush with stall or hazard: flush wins and the buffer clears.
  - Stall with hazard: the buffer holds and no bubble is inserted.
  - Writeback coinciding with a read of the same register: the read returns `i_wb_val`.
- Reset asserted mid-stall: the buffer clears asynchronously and the stall state is discarded.

## Test plan
- Reset, then write r3=0x1234 via writeback; the next cycle issue ADD r1,r3,r0 -> `o_sr1_val=0x1234`, `o_sr2_val=0`, `o_dr=1`.
- With r2=5 in the file, `i_of1_reg=2`/`i_of1_val=9` and `i_of2_reg=2`/`i_of2_val=7`, read r2 -> 9. With `i_of1_reg=0` -> 7. With `i_of2_reg=0` too -> 5.
- With `i_ld_pend_reg=4`, issue SUB r5,r4,r6 -> the buffer is all zeros and `o_pipe_stall=1`. The next cycle, with `i_ld_pend_reg=0` and `i_of2_reg=4`/`i_of2_val=0xAA`, the instruction issues with `o_sr1_val=0xAA`.
- With `i_use_imm=1`, `i_sr2=4`, `i_ld_pend_reg=4`, `i_imm=0xFFFFFFFC` -> no hazard, `o_sr2_val=0xFFFFFFFC`.
- Hold `i_pipe_stall=1` for 3 cycles while the inputs change -> outputs are unchanged and `o_pipe_stall=1`. Assert `i_pipe_flush` together with the stall -> all outputs are 0 the next cycle.
- Drop `i_reset_n` between clock edges while the buffer holds a branch (`o_opcode=0x0C`) -> outputs are 0 before the next edge, and r3 reads back 0.
